debug_trace: RTL and testbench

Parametrised bus-trace capture and dump engine for on-target debugging of the GB core. It records CPU/PPU bus accesses into a circular buffer and freezes on a trigger: either a rising edge of `trig` (e.g. halt) or a match on an address. After a programmable number of post-trigger accesses, it streams every stored access as an ASCII hex line through a byte handshake to the existing UART transmitter. It generalises the fixed single-snapshot halt dump to a multi-entry history with configurable widths, depth, post-trigger window and address-match triggering.

---
 rtl/debug_trace.sv | 140 ++++++++++++++
 tb/tb_debug_trace.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace.sv
// debug_trace: circular bus-trace buffer that freezes on a trigger and dumps
// every stored access oldest-first as ASCII hex lines over a byte handshake.
module debug_trace #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_en,
  input  logic [ADDR_W-1:0]        cap_addr,
  input  logic [DATA_W-1:0]        cap_data,
  input  logic                     cap_wr,
  input  logic                     trig,
  input  logic                     match_en,
  input  logic [ADDR_W-1:0]        match_addr,
  input  logic                     rearm,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int NA = ADDR_W / 4;
  localparam int ND = DATA_W / 4;
  localparam int L  = NA + ND + 5;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int PW = $clog2(L);
  localparam logic [1:0] S_CAP = 2'd0, S_POST = 2'd1, S_DUMP = 2'd2, S_DONE = 2'd3;

  logic [ADDR_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_d [DEPTH];
  logic              r_mem_w [DEPTH];
  logic [1:0]        r_state, w_next;
  logic [IW-1:0]     r_wr_ptr, r_post, w_start, w_rd;
  logic [CW-1:0]     r_count, r_ent;
  logic [PW-1:0]     r_pos;
  logic              r_last, r_trig_q, r_tx_valid;
  logic [7:0]        r_tx_data, w_byte;
  logic [3:0]        w_an, w_dn;
  logic              w_cap, w_trig;
  int                w_p, w_ai, w_di;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
  endfunction

  assign w_cap   = cap_en && (r_state == S_CAP || r_state == S_POST);
  assign w_trig  = (trig && !r_trig_q) || (match_en && cap_en && cap_addr == match_addr);
  assign w_start = r_wr_ptr - r_count[IW-1:0];
  assign w_rd    = w_start + r_ent[IW-1:0];

  // Byte at line position r_pos of the entry currently being dumped
  always_comb begin
    w_p    = int'(r_pos);
    w_ai   = (w_p < NA) ? NA - 1 - w_p : 0;
    w_di   = (w_p > NA && w_p <= NA + ND) ? NA + ND - w_p : 0;
    w_an   = 4'(r_mem_a[w_rd] >> (4 * w_ai));
    w_dn   = 4'(r_mem_d[w_rd] >> (4 * w_di));
    w_byte = (w_p < NA) ? hex(w_an) :
             (w_p == NA || w_p == NA + ND + 1) ? 8'h20 :
             (w_p <= NA + ND) ? hex(w_dn) :
             (w_p == NA + ND + 2) ? (r_mem_w[w_rd] ? 8'h57 : 8'h52) :
             (w_p == NA + ND + 3) ? 8'h0D : 8'h0A;
  end

  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_mem_a[r_wr_ptr] <= cap_addr;
      r_mem_d[r_wr_ptr] <= cap_data;
      r_mem_w[r_wr_ptr] <= cap_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CAP;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CAP:   w_next = w_trig ? ((POST_TRIG == 0) ? S_DUMP : S_POST) : S_CAP;
      S_POST:  w_next = (cap_en && r_post == IW'(1)) ? S_DUMP : S_POST;
      S_DUMP:  w_next = (r_count == '0 || (r_last && r_tx_valid && tx_ready)) ? S_DONE : S_DUMP;
      default: w_next = rearm ? S_CAP : S_DONE;
    endcase
  end

  always_comb begin
    state    = r_state;
    count    = r_count;
    tx_valid = r_tx_valid;
    tx_data  = r_tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_q   <= 1'b0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_post     <= '0;
      r_ent      <= '0;
      r_pos      <= '0;
      r_last     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_trig_q <= trig;
      if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != CW'(DEPTH)) r_count <= r_count + 1'b1;
      end
      if (r_state == S_CAP && w_trig) r_post <= IW'(POST_TRIG);
      else if (r_state == S_POST && cap_en) r_post <= r_post - 1'b1;
      if (r_state == S_DONE && rearm) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
      end
      // Dump cursor idles at zero outside DUMP so every dump starts cleanly
      if (r_state != S_DUMP) begin
        r_ent      <= '0;
        r_pos      <= '0;
        r_last     <= 1'b0;
        r_tx_valid <= 1'b0;
      end else if (!r_tx_valid || tx_ready) begin
        if (r_last || r_count == '0) r_tx_valid <= 1'b0;
        else begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= w_byte;
          r_last     <= (r_pos == PW'(L - 1)) && (r_ent == r_count - 1'b1);
          r_pos      <= (r_pos == PW'(L - 1)) ? '0 : r_pos + 1'b1;
          r_ent      <= (r_pos == PW'(L - 1)) ? r_ent + 1'b1 : r_ent;
        end
      end
    end
  end
endmodule

// File: tb/tb_debug_trace.sv
// tb_debug_trace: scoreboard bench for debug_trace, default build plus a
// narrow-address / wide-data build with no post-trigger window.
module tb_debug_trace;
  logic clk = 0, rst_n = 0;
  logic a_en = 0, a_wr = 0, a_trig = 0, a_men = 0, a_rearm = 0, a_rdy = 0;
  logic [15:0] a_addr = 0, a_madr = 0;
  logic [7:0]  a_din = 0, a_data;
  logic        a_vld;
  logic [1:0]  a_state;
  logic [4:0]  a_count;
  logic b_en = 0, b_wr = 0, b_trig = 0, b_men = 0, b_rearm = 0, b_rdy = 1;
  logic [7:0]  b_addr = 0, b_madr = 0, b_data;
  logic [15:0] b_din = 0;
  logic        b_vld;
  logic [1:0]  b_state;
  logic [2:0]  b_count;
  logic [7:0] qa[$], qb[$];
  int n_chk = 0, n_fail = 0, na_acc = 0;
  logic a_pv = 0, a_pr = 0, b_pv = 0, b_pr = 0;
  logic [7:0] a_pd = 0, b_pd = 0;
  logic [15:0] s1_a [7] = '{16'h1234, 16'hFF40, 16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400};
  logic [7:0]  s1_d [7] = '{8'hAB, 8'h91, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
  logic        s1_w [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  debug_trace u_a (
    .clk(clk), .rst_n(rst_n), .cap_en(a_en), .cap_addr(a_addr), .cap_data(a_din),
    .cap_wr(a_wr), .trig(a_trig), .match_en(a_men), .match_addr(a_madr),
    .rearm(a_rearm), .tx_data(a_data), .tx_valid(a_vld), .tx_ready(a_rdy),
    .state(a_state), .count(a_count)
  );

  debug_trace #(.ADDR_W(8), .DATA_W(16), .DEPTH(4), .POST_TRIG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .cap_en(b_en), .cap_addr(b_addr), .cap_data(b_din),
    .cap_wr(b_wr), .trig(b_trig), .match_en(b_men), .match_addr(b_madr),
    .rearm(b_rearm), .tx_data(b_data), .tx_valid(b_vld), .tx_ready(b_rdy),
    .state(b_state), .count(b_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put(input bit b, input logic [7:0] v);
    if (b) qb.push_back(v);
    else   qa.push_back(v);
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  task automatic push_line(input bit b, input logic [31:0] a, input int na,
                           input logic [31:0] d, input int nd, input bit w);
    for (int i = na - 1; i >= 0; i--) put(b, hx(4'(a >> (4 * i))));
    put(b, 8'h20);
    for (int i = nd - 1; i >= 0; i--) put(b, hx(4'(d >> (4 * i))));
    put(b, 8'h20);
    put(b, w ? 8'h57 : 8'h52);
    put(b, 8'h0D);
    put(b, 8'h0A);
  endtask

  task automatic push_lit(input bit b, input logic [87:0] v);
    for (int i = 10; i >= 0; i--) put(b, v[i*8 +: 8]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap_a(input logic [15:0] ad, input logic [7:0] d, input logic w);
    a_en = 1; a_addr = ad; a_din = d; a_wr = w;
    step();
    a_en = 0;
  endtask

  task automatic wait_a_done(input string nm);
    for (int i = 0; i < 3000 && a_state != 2'd3; i++) step();
    chk(nm, a_state, 2'd3);
  endtask

  task automatic rearm_a();
    a_rearm = 1;
    step();
    a_rearm = 0;
    chk("rearm_state", a_state, 2'd0);
    chk("rearm_count", a_count, 5'd0);
  endtask

  // Scenario 1 capture sequence, with a second trig edge inside the POST window
  task automatic run_s1();
    push_lit(0, 88'h31_32_33_34_20_41_42_20_57_0D_0A);
    for (int i = 1; i < 7; i++) push_line(0, 32'(s1_a[i]), 4, 32'(s1_d[i]), 2, s1_w[i]);
    for (int i = 0; i < 3; i++) cap_a(s1_a[i], s1_d[i], s1_w[i]);
    a_trig = 1;
    step();
    a_trig = 0;
    chk("s1_post", a_state, 2'd1);
    cap_a(s1_a[3], s1_d[3], s1_w[3]);
    a_trig = 1;
    step();
    a_trig = 0;
    chk("post_trig_ignored", a_state, 2'd1);
    cap_a(s1_a[4], s1_d[4], s1_w[4]);
    cap_a(s1_a[5], s1_d[5], s1_w[5]);
    chk("s1_still_post", a_state, 2'd1);
    cap_a(s1_a[6], s1_d[6], s1_w[6]);
    chk("s1_dump", a_state, 2'd2);
    chk("s1_count", a_count, 5'd7);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      a_pv = 0;
      b_pv = 0;
    end else begin
      if (a_pv && !a_pr) begin
        chk("a_hold_valid", a_vld, 1);
        chk("a_hold_data", a_data, a_pd);
      end
      if (a_vld && a_rdy) begin
        na_acc++;
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_extra_byte: got %0h expected none", a_data);
        end else chk("a_byte", a_data, qa.pop_front());
      end
      a_pv = a_vld; a_pr = a_rdy; a_pd = a_data;
      if (b_pv && !b_pr) chk("b_hold_data", b_data, b_pd);
      if (b_vld && b_rdy) begin
        if (qb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_extra_byte: got %0h expected none", b_data);
        end else chk("b_byte", b_data, qb.pop_front());
      end
      b_pv = b_vld; b_pr = b_rdy; b_pd = b_data;
    end
  end

  initial begin
    int n, base;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_state", a_state, 2'd0);
    chk("rst_count", a_count, 5'd0);
    chk("rst_valid", a_vld, 0);
    chk("rst_data", a_data, 8'h00);

    // Narrow build: empty-buffer trigger, then a single-entry dump
    chk("b_rst_state", b_state, 2'd0);
    b_trig = 1;
    step();
    b_trig = 0;
    chk("b_empty_dump", b_state, 2'd2);
    step();
    chk("b_empty_done", b_state, 2'd3);
    chk("b_empty_valid", b_vld, 0);
    chk("b_empty_count", b_count, 3'd0);
    b_rearm = 1;
    step();
    b_rearm = 0;
    chk("b_rearm", b_state, 2'd0);
    push_lit(1, 88'h33_46_20_42_45_45_46_20_52_0D_0A);
    b_en = 1; b_addr = 8'h3F; b_din = 16'hBEEF; b_wr = 0;
    step();
    b_en = 0;
    b_trig = 1;
    step();
    b_trig = 0;
    chk("b_dump", b_state, 2'd2);
    for (int i = 0; i < 200 && b_state != 2'd3; i++) step();
    chk("b_done", b_state, 2'd3);
    chk("b_queue_empty", qb.size(), 0);
    chk("b_count", b_count, 3'd1);

    // Scenario 1, ready tied high, with exact latency and length checks
    a_rdy = 1;
    run_s1();
    chk("first_valid_latency", a_vld, 0);
    a_rearm = 1;
    step();
    a_rearm = 0;
    chk("first_valid", a_vld, 1);
    chk("rearm_in_dump_ignored", a_state, 2'd2);
    n = 0;
    while (a_state != 2'd3 && n < 2000) begin
      step();
      n++;
    end
    chk("dump_cycles", n, 77);
    chk("s1_queue_empty", qa.size(), 0);
    chk("s1_done_count", a_count, 5'd7);
    rearm_a();

    // Scenario 2: wraparound plus address-match trigger
    for (int i = 0; i < 20; i++) cap_a(16'(i), 8'(i), 1'b0);
    chk("s2_saturated", a_count, 5'd16);
    a_men = 1; a_madr = 16'h0014;
    push_lit(0, 88'h30_30_30_39_20_30_39_20_52_0D_0A);
    for (int i = 10; i < 25; i++) push_line(0, 32'(i), 4, 32'(i), 2, 1'b0);
    cap_a(16'h0014, 8'h14, 1'b0);
    chk("s2_match_post", a_state, 2'd1);
    a_men = 0;
    for (int i = 21; i < 25; i++) cap_a(16'(i), 8'(i), 1'b0);
    chk("s2_dump", a_state, 2'd2);
    chk("s2_count", a_count, 5'd16);
    wait_a_done("s2_done");
    chk("s2_queue_empty", qa.size(), 0);
    rearm_a();

    // Scenario 3: backpressure, long stall mid-line then random ready
    a_rdy = 0;
    run_s1();
    for (int k = 0; k < 3000 && a_state != 2'd3; k++) begin
      a_rdy = (k < 5) ? 1'b1 : (k < 15) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
    end
    chk("bp_done", a_state, 2'd3);
    chk("bp_queue_empty", qa.size(), 0);
    rearm_a();

    // Scenario 4: asynchronous reset after five accepted bytes
    a_rdy = 1;
    base = na_acc;
    run_s1();
    for (int i = 0; i < 200 && na_acc < base + 5; i++) step();
    chk("pre_reset_accepted", na_acc - base, 5);
    chk("pre_reset_valid", a_vld, 1);
    #2 rst_n = 0;
    #1 chk("async_reset_valid", a_vld, 0);
    qa.delete();
    qb.delete();
    step();
    step();
    rst_n = 1;
    step();
    chk("post_reset_state", a_state, 2'd0);
    chk("post_reset_count", a_count, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
